// File: rtl/l1_line_xfer.sv
// l1_line_xfer: moves one cache line between the L1 controller and word memory.
//   clk, rst (async, active-low)
//   req__valid/ready/we/line_addr/wr_line : line request from the cache controller
//   resp__valid/rd_line                   : one-cycle completion pulse and filled line
//   l1_to_mem__en/we/addr/wr_data/rd_data : per-word memory beats, read data 1 cycle late
module l1_line_xfer #(
  parameter int WORDS = 4,
  parameter int WORDS__LOG2 = 2,
  parameter int ADDR_WIDTH = 61,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req__valid,
  output logic                                req__ready,
  input  logic                                req__we,
  input  logic [ADDR_WIDTH-WORDS__LOG2-1:0]   req__line_addr,
  input  logic [WORDS*DATA_WIDTH-1:0]         req__wr_line,
  output logic                                resp__valid,
  output logic [WORDS*DATA_WIDTH-1:0]         resp__rd_line,
  output logic [ADDR_WIDTH-1:0]               l1_to_mem__addr,
  output logic [DATA_WIDTH-1:0]               l1_to_mem__wr_data,
  input  logic [DATA_WIDTH-1:0]               l1_to_mem__rd_data,
  output logic                                l1_to_mem__en,
  output logic                                l1_to_mem__we
);
  localparam int LW = ADDR_WIDTH - WORDS__LOG2;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [WORDS__LOG2-1:0] cnt, cnt_d, cap_idx;
  logic [LW-1:0] line_q, line_src;
  logic [WORDS*DATA_WIDTH-1:0] wr_line_q, wr_src;
  logic en_d, we_d, valid_d, accept, last, cap_en;
  assign accept = req__ready && req__valid;
  assign last = cnt == WORDS__LOG2'(WORDS - 1);
  // the first beat is registered at the acceptance edge, before line_q/wr_line_q hold the request
  assign line_src = accept ? req__line_addr : line_q;
  assign wr_src = accept ? req__wr_line : wr_line_q;
  // read data trails its beat by one cycle: word cnt-1 arrives while beat cnt is out, the last one in DRAIN
  assign cap_en = (state == READ && cnt != '0) || state == DRAIN;
  assign cap_idx = state == DRAIN ? cnt : cnt - 1'b1;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    en_d = 1'b0;
    we_d = 1'b0;
    valid_d = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        state_d = req__we ? WRITE : READ;
        cnt_d = '0;
        en_d = 1'b1;
        we_d = req__we;
      end
      WRITE, READ: if (last) begin
        state_d = state == WRITE ? DONE : DRAIN;
        valid_d = state == WRITE;
      end else begin
        cnt_d = cnt + 1'b1;
        en_d = 1'b1;
        we_d = state == WRITE;
      end
      DRAIN: begin
        state_d = DONE;
        valid_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      line_q <= '0;
      wr_line_q <= '0;
      req__ready <= 1'b0;
      resp__valid <= 1'b0;
      resp__rd_line <= '0;
      l1_to_mem__en <= 1'b0;
      l1_to_mem__we <= 1'b0;
      l1_to_mem__addr <= '0;
      l1_to_mem__wr_data <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      req__ready <= state_d == IDLE;
      resp__valid <= valid_d;
      l1_to_mem__en <= en_d;
      l1_to_mem__we <= we_d;
      l1_to_mem__addr <= en_d ? {line_src, cnt_d} : '0;
      l1_to_mem__wr_data <= we_d ? wr_src[cnt_d*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (accept) begin
        line_q <= req__line_addr;
        wr_line_q <= req__wr_line;
      end
      if (cap_en) resp__rd_line[cap_idx*DATA_WIDTH +: DATA_WIDTH] <= l1_to_mem__rd_data;
    end
  end
endmodule

// File: tb/tb_l1_line_xfer.sv
// tb_l1_line_xfer: directed and random line transfers checked against a timeline model.
module tb_l1_line_xfer;
  localparam int W = 4;
  localparam int AW = 61;
  localparam int DW = 64;
  localparam int LW = 59;
  logic clk = 1'b0;
  logic rst;
  logic req__valid, req__ready, req__we;
  logic [LW-1:0] req__line_addr;
  logic [W*DW-1:0] req__wr_line, resp__rd_line;
  logic resp__valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;
  logic en, we;
  l1_line_xfer #(.WORDS(W), .WORDS__LOG2(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req__valid(req__valid), .req__ready(req__ready), .req__we(req__we),
    .req__line_addr(req__line_addr), .req__wr_line(req__wr_line),
    .resp__valid(resp__valid), .resp__rd_line(resp__rd_line),
    .l1_to_mem__addr(addr), .l1_to_mem__wr_data(wr_data), .l1_to_mem__rd_data(rd_data),
    .l1_to_mem__en(en), .l1_to_mem__we(we)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] ref_mem [4096];
  logic [AW-1:0] ba [$];
  logic bw [$];
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  function automatic logic [11:0] midx(input logic [LW-1:0] l, input int k);
    logic [AW-1:0] a;
    a = {l, 2'(k)};
    return a[11:0];
  endfunction
  task automatic preload(input int a, input logic [DW-1:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask
  // memory with one cycle of read latency
  always @(posedge clk)
    if (en) begin
      if (we) mem[addr[11:0]] <= wr_data;
      else rd_data <= mem[addr[11:0]];
    end
  // timeline model: every output follows from the age of the current request
  logic m_busy = 1'b0, m_ready = 1'b0, m_we = 1'b0;
  int m_t0 = 0;
  logic [LW-1:0] m_line = '0;
  logic [W*DW-1:0] m_data = '0, m_rd = '0;
  always @(posedge clk) begin
    int d;
    if (!rst) begin
      m_busy = 1'b0;
      m_ready = 1'b0;
      m_rd = '0;
    end else begin
      d = cyc - m_t0;
      if (m_busy) begin
        if (m_we && d >= 1 && d <= W) ref_mem[midx(m_line, d - 1)] = m_data[(d-1)*DW +: DW];
        if (!m_we && d >= 2 && d <= W + 1) m_rd[(d-2)*DW +: DW] = ref_mem[midx(m_line, d - 2)];
        if (d == (m_we ? W + 1 : W + 2)) begin
          m_busy = 1'b0;
          m_ready = 1'b1;
        end
      end else if (m_ready && req__valid) begin
        m_busy = 1'b1;
        m_ready = 1'b0;
        m_t0 = cyc;
        m_we = req__we;
        m_line = req__line_addr;
        m_data = req__wr_line;
      end else m_ready = 1'b1;
    end
    cyc++;
  end
  always @(negedge clk) begin
    int d;
    logic e_en;
    d = cyc - m_t0;
    e_en = m_busy && d >= 1 && d <= W;
    chk("ready", req__ready, m_ready);
    chk("resp_valid", resp__valid, m_busy && d == (m_we ? W + 1 : W + 2));
    chk("en", en, e_en);
    chk("we", we, e_en && m_we);
    chk("addr", addr, e_en ? {m_line, 2'(d - 1)} : '0);
    chk("wr_data", wr_data, (e_en && m_we) ? m_data[(d-1)*DW +: DW] : '0);
    chk("rd_line", resp__rd_line, m_rd);
    if (en) begin
      ba.push_back(addr);
      bw.push_back(we);
    end
  end
  task automatic xfer(input logic w, input logic [LW-1:0] line, input logic [W*DW-1:0] data, output int lat);
    int n;
    @(negedge clk);
    req__valid = 1'b1;
    req__we = w;
    req__line_addr = line;
    req__wr_line = data;
    ba.delete();
    bw.delete();
    n = 0;
    while (!req__ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_seen", req__ready, 1);
    @(negedge clk);
    req__valid = 1'b0;
    req__we = 1'($urandom);
    req__line_addr = LW'({$urandom, $urandom});
    for (int i = 0; i < 8; i++) req__wr_line[i*32 +: 32] = $urandom;
    lat = 1;
    while (!resp__valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_seen", resp__valid, 1);
  endtask
  initial begin
    int lat, a1, a2, nv, n;
    logic w;
    logic [LW-1:0] line;
    logic [W*DW-1:0] fill_exp, wb, data;
    rst = 1'b0;
    req__valid = 1'b0;
    req__we = 1'b0;
    req__line_addr = '0;
    req__wr_line = '0;
    for (int i = 0; i < 4096; i++) preload(i, {$urandom, $urandom});
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", req__ready, 0);
      chk("rst_en", en, 0);
      chk("rst_rd_line", resp__rd_line, 0);
    end
    rst = 1'b1;
    #1 chk("ready_before_edge", req__ready, 0);
    @(negedge clk);
    chk("ready_one_edge", req__ready, 1);
    repeat (2) begin
      @(negedge clk);
      chk("idle_en", en, 0);
    end
    for (int k = 0; k < 4; k++) preload(12'h40 + k, 64'hA0 + k);
    fill_exp = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    xfer(1'b0, 59'h10, '0, lat);
    chk("fill_lat", lat, 6);
    chk("fill_nbeats", ba.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("fill_addr", ba[k], 61'h40 + k);
      chk("fill_we", bw[k], 0);
    end
    chk("fill_line", resp__rd_line, fill_exp);
    wb = {64'd4, 64'd3, 64'd2, 64'd1};
    xfer(1'b1, 59'h20, wb, lat);
    chk("wb_lat", lat, 5);
    chk("wb_nbeats", ba.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("wb_addr", ba[k], 61'h80 + k);
      chk("wb_we", bw[k], 1);
    end
    chk("wb_keeps_line", resp__rd_line, fill_exp);
    xfer(1'b0, 59'h20, '0, lat);
    chk("wb_refill", resp__rd_line, wb);
    @(negedge clk);
    req__valid = 1'b1;
    req__we = 1'b0;
    req__line_addr = 59'h10;
    a1 = -1;
    a2 = -1;
    for (int i = 0; i < 30 && a2 < 0; i++) begin
      if (a1 >= 0 && cyc == a1 + 6) chk("b2b_done_no_accept", req__ready, 0);
      if (req__ready) begin
        if (a1 < 0) a1 = cyc;
        else a2 = cyc;
      end
      @(negedge clk);
    end
    req__valid = 1'b0;
    chk("b2b_period", a2 - a1, 7);
    repeat (10) @(negedge clk);
    req__valid = 1'b1;
    req__we = 1'b0;
    req__line_addr = 59'h10;
    n = 0;
    while (!req__ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req__valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_beat2_addr", addr, 61'h42);
    #2 rst = 1'b0;
    #1;
    chk("abort_en", en, 0);
    chk("abort_rd_line", resp__rd_line, 0);
    chk("abort_ready", req__ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      nv += int'(resp__valid);
    end
    chk("abort_no_resp", nv, 0);
    xfer(1'b0, 59'h10, '0, lat);
    chk("refill_lat", lat, 6);
    chk("refill_line", resp__rd_line, fill_exp);
    for (int k = 0; k < 4; k++) preload(12'hFFC + k, 64'hDEAD_0000 + k);
    xfer(1'b0, '1, '0, lat);
    chk("top_nbeats", ba.size(), 4);
    for (int k = 0; k < 4; k++) chk("top_addr", ba[k], {{LW{1'b1}}, 2'(k)});
    chk("top_last_all_ones", ba[3], {AW{1'b1}});
    chk("top_line", resp__rd_line, {64'hDEAD_0003, 64'hDEAD_0002, 64'hDEAD_0001, 64'hDEAD_0000});
    repeat (40) begin
      w = 1'($urandom_range(0, 1));
      line = LW'({$urandom, $urandom});
      for (int i = 0; i < 8; i++) data[i*32 +: 32] = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xfer(w, line, data, lat);
      chk("rand_lat", lat, w ? 5 : 6);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected $finish");
    $fatal(1);
  end
endmodule

// File: doc/l1_line_xfer.md
# l1_line_xfer

Line-transfer engine on the initiator side of the `l1_to_mem` interface, between the L1 cache controller and the 64-bit word memory. It accepts one line request at a time: either a fill (read) or a writeback (write) of `WORDS` consecutive words. It sequences the per-word `en`/`we`/`addr`/`wr_data` beats to memory and, for fills, assembles the returned words into one line. It then returns a one-cycle completion pulse to the cache controller.

## Interface
- `WORDS`, 4: words per line; must be a power of two and at least 2.
- `WORDS__LOG2`, 2: log2(`WORDS`).
- `ADDR_WIDTH`, 61: memory word-address width; must be greater than `WORDS__LOG2`.
- `DATA_WIDTH`, 64: memory word width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req__valid`  in  1  request present.
- `req__ready`  out  1  engine idle and able to accept a request.
- `req__we`  in  1  1 = writeback, 0 = fill.
- `req__line_addr`  in  `ADDR_WIDTH-WORDS__LOG2`  line address.
- `req__wr_line`  in  `WORDS*DATA_WIDTH`  writeback data; word k is in bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `resp__valid`  out  1  one-cycle completion pulse.
- `resp__rd_line`  out  `WORDS*DATA_WIDTH`  filled line; word packing is the same as `req__wr_line`.
- `l1_to_mem__addr`  out  `ADDR_WIDTH`  memory word address.
- `l1_to_mem__wr_data`  out  `DATA_WIDTH`  memory write data.
- `l1_to_mem__rd_data`  in  `DATA_WIDTH`  memory read data; valid in the cycle after a read beat.
- `l1_to_mem__en`  out  1  memory access enable.
- `l1_to_mem__we`  out  1  memory write enable.

## Operation
- The states are IDLE, WRITE, READ, DRAIN and DONE. All outputs are registered.
- Reset (`rst`=0), asynchronous:
  - State goes to IDLE.
  - `req__ready`, `resp__valid`, `l1_to_mem__en` and `l1_to_mem__we` all go to 0.
  - `l1_to_mem__addr`, `l1_to_mem__wr_data` and `resp__rd_line` all go to 0.
  - The word counter goes to 0.
- `req__ready` rises on the first rising edge after `rst` deasserts. It is 1 only while the state is IDLE.
- Acceptance happens when `req__valid` and `req__ready` are both 1 at a rising edge.
  - `req__we`, `req__line_addr` and `req__wr_line` are captured internally at that edge.
  - `req__ready` drops to 0 at the same edge.
  - Request inputs are ignored at all other times.
- Beat address is `{line_addr, k}`, for k = 0..`WORDS`-1.
  - The word index never carries into the line field.
  - With an all-ones line address, the last beat is address all-ones.
- WRITE: issues beats k = 0..`WORDS`-1 on consecutive cycles.
  - Each beat drives `en`=1, `we`=1 and `wr_data` = word k.
  - After the last beat the engine goes to DONE.
- READ: issues beats k = 0..`WORDS`-1 on consecutive cycles.
  - Each beat drives `en`=1 and `we`=0.
  - `rd_data` is sampled one cycle after each beat and written into word k of `resp__rd_line`.
  - After the last beat the engine goes to DRAIN.
- DRAIN: one cycle; `en`=0 and the last word is captured. The engine then goes to DONE.
- DONE: `resp__valid`=1 for exactly one cycle. The engine then goes to IDLE, with `req__ready`=1.
- In any cycle that is not a beat: `en`=0, `we`=0, `addr`=0 and `wr_data`=0.
- `resp__rd_line` changes only during READ/DRAIN captures or reset.
  - It holds its value across writebacks.
  - It is stable and complete while `resp__valid`=1.
- Reset during a transfer aborts it immediately.
  - No `resp__valid` is produced.
  - Partially captured words are cleared to 0.

## Timing
Cycle 0 is the acceptance cycle.
- Beats occur in cycles 1..`WORDS`. Beat k occurs in cycle k+1.
- Writeback:
  - `resp__valid` is 1 in cycle `WORDS`+1.
  - `req__ready` is 1 from cycle `WORDS`+2.
  - Request-to-request period is `WORDS`+2 cycles.
- Fill:
  - Word k is captured at the end of cycle k+2.
  - DRAIN is cycle `WORDS`+1.
  - `resp__valid` is 1 in cycle `WORDS`+2.
  - `req__ready` is 1 from cycle `WORDS`+3.
  - Request-to-request period is `WORDS`+3 cycles.
- There is no acceptance in the DONE cycle, even if `req__valid`=1.
- `req__valid` held at 1 continuously with the same request produces back-to-back transfers at the periods above.

## Test plan
With `WORDS`=4, `ADDR_WIDTH`=61 and a 1-cycle-latency memory model (the 4096-deep `mem` with its address taken from the low 12 bits):
- **Reset values:** hold `rst`=0 for 3 cycles, then release.
  - While in reset, all outputs are 0.
  - `req__ready`=1 exactly one edge after release.
  - `en` stays 0 while idle.
- **Fill:** preload words 0x40..0x43 with 0xA0..0xA3, then fill line 0x10.
  - Beats to addresses 0x40, 0x41, 0x42, 0x43 occur in cycles 1..4.
  - `resp__valid` occurs in cycle 6.
  - `resp__rd_line` = {0xA3, 0xA2, 0xA1, 0xA0}.
- **Writeback then fill:** write back line 0x20 with data {4, 3, 2, 1}.
  - `we`=1 on beats to addresses 0x80..0x83.
  - `resp__valid` occurs in cycle 5.
  - `resp__rd_line` is unchanged by the writeback.
  - A following fill of line 0x20 returns {4, 3, 2, 1}.
- **Back-to-back:** hold `req__valid`=1 for two fills.
  - The second acceptance occurs exactly 7 cycles after the first.
  - There is no acceptance in the DONE cycle.
- **Reset mid-fill:** assert `rst` during beat 2.
  - `en` drops to 0 immediately and `resp__rd_line` is 0.
  - No `resp__valid` is produced.
  - The next fill completes normally.
- **Top line:** fill with line address all-ones.
  - Beat addresses are ...FFC..FFF, ending at all-ones.
  - There is no wrap into line 0.
